// File: rtl/clock_min_hour_keeper.sv
// clock_min_hour_keeper: BCD minutes/hours keeper with time-set FSM; in clk,rst,CAR(seconds carry level),mode_btn,inc_btn; out MIN1,MIN10,HR1,HR10,HR_CAR,MODE
module clock_min_hour_keeper #(
  parameter bit H24 = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       CAR,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [3:0] MIN1,
  output logic [2:0] MIN10,
  output logic [3:0] HR1,
  output logic [1:0] HR10,
  output logic       HR_CAR,
  output logic [1:0] MODE
);
  typedef enum logic [1:0] {RUN = 2'd0, SET_HOUR = 2'd1, SET_MIN = 2'd2} state_t;
  state_t state, state_n;
  logic car_prev, tick, run_tick, inc_h, inc_m, min_wrap, hr_wrap, hr_car;
  logic [3:0] min1, min1_n, hr1, hr1_n;
  logic [2:0] min10, min10_n;
  logic [1:0] hr10, hr10_n;
  always_comb begin
    tick     = CAR & ~car_prev;
    run_tick = (state == RUN) & tick;
    inc_h    = (state == SET_HOUR) & inc_btn & ~mode_btn;
    inc_m    = (state == SET_MIN) & inc_btn & ~mode_btn;
    min_wrap = (min10 == 3'd5) & (min1 == 4'd9);
    min1_n   = (min1 == 4'd9) ? 4'd0 : min1 + 4'd1;
    min10_n  = (min1 != 4'd9) ? min10 : (min_wrap ? 3'd0 : min10 + 3'd1);
    hr_wrap  = H24 ? (hr10 == 2'd2) & (hr1 == 4'd3) : (hr10 == 2'd1) & (hr1 == 4'd2);
    hr1_n    = hr_wrap ? (H24 ? 4'd0 : 4'd1) : ((hr1 == 4'd9) ? 4'd0 : hr1 + 4'd1);
    hr10_n   = hr_wrap ? 2'd0 : ((hr1 == 4'd9) ? hr10 + 2'd1 : hr10);
    state_n  = (state == RUN)      ? (mode_btn ? SET_HOUR : RUN) :
               (state == SET_HOUR) ? (mode_btn ? SET_MIN : SET_HOUR) :
               (state == SET_MIN)  ? (mode_btn ? RUN : SET_MIN) : RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      car_prev <= 1'b1;
      min1     <= 4'd0;
      min10    <= 3'd0;
      hr1      <= H24 ? 4'd0 : 4'd2;
      hr10     <= H24 ? 2'd0 : 2'd1;
      hr_car   <= 1'b0;
    end else begin
      state    <= state_n;
      car_prev <= CAR;
      hr_car   <= run_tick & min_wrap & hr_wrap;
      if (run_tick | inc_m) begin
        min1  <= min1_n;
        min10 <= min10_n;
      end
      if ((run_tick & min_wrap) | inc_h) begin
        hr1  <= hr1_n;
        hr10 <= hr10_n;
      end
    end
  end
  assign MIN1   = min1;
  assign MIN10  = min10;
  assign HR1    = hr1;
  assign HR10   = hr10;
  assign HR_CAR = hr_car;
  assign MODE   = state;
endmodule

// File: tb/tb_clock_min_hour_keeper.sv
// tb_clock_min_hour_keeper: checks 24h and 12h instances with directed vectors, hand sequences and random stimulus against an integer model
module tb_clock_min_hour_keeper;
  logic clk, rst, car, mode_btn, inc_btn;
  logic [3:0] min1_a, hr1_a, min1_b, hr1_b;
  logic [2:0] min10_a, min10_b;
  logic [1:0] hr10_a, hr10_b, mode_a, mode_b;
  logic hc_a, hc_b;
  logic [15:0] act24, act12;
  int checks = 0, failures = 0;
  int m = 0, h24 = 0, h12 = 12, md = 0, hc24 = 0, hc12 = 0;
  bit cp = 1;
  typedef struct {bit r, c, mb, ib; int mm, hh, hc, mo;} vec_t;
  vec_t tv[20];
  clock_min_hour_keeper #(.H24(1'b1)) u24 (
    .clk(clk), .rst(rst), .CAR(car), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .MIN1(min1_a), .MIN10(min10_a), .HR1(hr1_a), .HR10(hr10_a), .HR_CAR(hc_a), .MODE(mode_a)
  );
  clock_min_hour_keeper #(.H24(1'b0)) u12 (
    .clk(clk), .rst(rst), .CAR(car), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .MIN1(min1_b), .MIN10(min10_b), .HR1(hr1_b), .HR10(hr10_b), .HR_CAR(hc_b), .MODE(mode_b)
  );
  assign act24 = {min1_a, min10_a, hr1_a, hr10_a, hc_a, mode_a};
  assign act12 = {min1_b, min10_b, hr1_b, hr10_b, hc_b, mode_b};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [15:0] pack(input int mm, hh, hc, mo);
    return {4'(mm % 10), 3'(mm / 10), 4'(hh % 10), 2'(hh / 10), 1'(hc), 2'(mo)};
  endfunction
  task automatic check(input string nm, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (min1,min10,hr1,hr10,hrcar,mode) t=%0t", nm, a, e, $time);
    end
  endtask
  task automatic model_step(input bit r, c, mb, ib);
    if (r) begin
      m = 0; h24 = 0; h12 = 12; md = 0; cp = 1; hc24 = 0; hc12 = 0;
    end else begin
      bit tk;
      tk = c && !cp;
      cp = c;
      hc24 = 0;
      hc12 = 0;
      if (md == 0 && tk) begin
        m++;
        if (m == 60) begin
          m = 0;
          h24 = (h24 + 1) % 24;
          hc24 = (h24 == 0);
          h12 = h12 % 12 + 1;
          hc12 = (h12 == 1);
        end
      end else if (ib && !mb && md == 1) begin
        h24 = (h24 + 1) % 24;
        h12 = h12 % 12 + 1;
      end else if (ib && !mb && md == 2) begin
        m = (m + 1) % 60;
      end
      if (mb) md = (md + 1) % 3;
    end
  endtask
  task automatic cyc(input bit r, c, mb, ib);
    rst = r; car = c; mode_btn = mb; inc_btn = ib;
    @(posedge clk);
    model_step(r, c, mb, ib);
    #1;
    check("model24", act24, pack(m, h24, hc24, md));
    check("model12", act12, pack(m, h12, hc12, md));
  endtask
  task automatic expect24(input string nm, input int mm, hh, hc, mo);
    check(nm, act24, pack(mm, hh, hc, mo));
  endtask
  task automatic expect12(input string nm, input int mm, hh, hc, mo);
    check(nm, act12, pack(mm, hh, hc, mo));
  endtask
  initial begin
    rst = 1'b1; car = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;
    tv[0]  = '{1, 1, 0, 0, 0, 0, 0, 0};
    tv[1]  = '{0, 1, 0, 0, 0, 0, 0, 0};
    tv[2]  = '{0, 1, 0, 0, 0, 0, 0, 0};
    tv[3]  = '{0, 1, 0, 0, 0, 0, 0, 0};
    tv[4]  = '{0, 1, 0, 0, 0, 0, 0, 0};
    tv[5]  = '{0, 1, 0, 0, 0, 0, 0, 0};
    tv[6]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    tv[7]  = '{0, 1, 0, 0, 1, 0, 0, 0};
    tv[8]  = '{0, 1, 0, 0, 1, 0, 0, 0};
    tv[9]  = '{0, 0, 0, 0, 1, 0, 0, 0};
    tv[10] = '{0, 1, 1, 0, 2, 0, 0, 1};
    tv[11] = '{0, 1, 0, 1, 2, 1, 0, 1};
    tv[12] = '{0, 1, 1, 1, 2, 1, 0, 2};
    tv[13] = '{0, 1, 0, 1, 3, 1, 0, 2};
    tv[14] = '{0, 0, 0, 0, 3, 1, 0, 2};
    tv[15] = '{0, 1, 0, 0, 3, 1, 0, 2};
    tv[16] = '{0, 1, 1, 0, 3, 1, 0, 0};
    tv[17] = '{0, 0, 0, 0, 3, 1, 0, 0};
    tv[18] = '{0, 1, 0, 0, 4, 1, 0, 0};
    tv[19] = '{1, 0, 0, 0, 0, 0, 0, 0};
    repeat (2) @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      cyc(tv[i].r, tv[i].c, tv[i].mb, tv[i].ib);
      expect24($sformatf("vec%0d", i), tv[i].mm, tv[i].hh, tv[i].hc, tv[i].mo);
    end
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    repeat (23) cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 0);
    repeat (59) cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 0);
    expect24("preset24", 59, 23, 0, 0);
    expect12("preset12", 59, 11, 0, 0);
    cyc(0, 1, 0, 0);
    expect24("rollover24", 0, 0, 1, 0);
    expect12("noon12", 0, 12, 0, 0);
    cyc(0, 1, 0, 0);
    expect24("hrcar_one_cycle", 0, 0, 0, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 0);
    repeat (59) cyc(0, 1, 0, 1);
    cyc(0, 1, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    expect12("rollover12", 0, 1, 1, 0);
    expect24("h24_0100", 0, 1, 0, 0);
    cyc(0, 1, 1, 0);
    repeat (25) cyc(0, 1, 0, 1);
    expect24("set_hour_wrap", 0, 2, 0, 1);
    cyc(0, 1, 1, 0);
    repeat (3) begin
      cyc(0, 0, 0, 0);
      cyc(0, 1, 0, 0);
    end
    expect24("set_min_no_tick", 0, 2, 0, 2);
    cyc(0, 1, 1, 1);
    expect24("mode_beats_inc", 0, 2, 0, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 0, 1);
    expect24("set_hour_inc", 0, 3, 0, 1);
    cyc(1, 1, 0, 1);
    expect24("rst_mid_set24", 0, 0, 0, 0);
    expect12("rst_mid_set12", 0, 12, 0, 0);
    repeat (4000)
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/clock_min_hour_keeper.md
Name: clock_min_hour_keeper

Overview:
- Downstream stage of the seconds counter. Consumes its carry level and keeps minutes (00-59) and hours in BCD. Hours are 00-23, or 01-12 when configured for 12-hour mode.
- Includes a three-state time-set FSM driven by two pre-debounced button pulses.
- Fully synchronous on one clock. The seconds carry is treated as data through edge detection, never as a clock.

Parameters:
- H24, 1, hour format: 1 = 24-hour (00-23), 0 = 12-hour (01-12)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  reset, synchronous, active-high
- CAR  input  1  seconds-stage carry level; high while seconds tens digit = 0; rising edge = one minute elapsed
- mode_btn  input  1  one-cycle pulse, advances set-mode FSM
- inc_btn  input  1  one-cycle pulse, increments field selected in set mode
- MIN1  output  4  minutes ones digit, BCD 0-9
- MIN10  output  3  minutes tens digit, 0-5
- HR1  output  4  hours ones digit, BCD 0-9
- HR10  output  2  hours tens digit, 0-2
- HR_CAR  output  1  one-cycle registered pulse on day/half-day rollover
- MODE  output  2  FSM state: 0 RUN, 1 SET_HOUR, 2 SET_MIN

Behaviour:
- Reset (rst high at a clk edge):
  - MIN = 00; HR = 00 if H24 = 1, else 12.
  - HR_CAR = 0, MODE = RUN.
  - car_prev = 1, so a CAR already high after reset does not count a minute.
- Edge detect:
  - tick = CAR & ~car_prev; car_prev <= CAR every cycle in every state.
  - Latency: CAR first sampled high at edge N with car_prev = 0 → counters hold the new value after edge N.
- RUN, on tick:
  - MIN increments with BCD digit arithmetic; ones 9 → 0 with tens+1.
  - 59 → 00, and hours increment in the same cycle.
- Hour increment (RUN):
  - H24 = 1: 23 → 00, with HR_CAR = 1 for the following cycle only.
  - H24 = 0: sequence 12,01,02,...,11,12; 12 → 01 asserts HR_CAR.
  - 09 → 10 and 19 → 20 via ones/tens carry.
- FSM, advancing only on mode_btn:
  - RUN → SET_HOUR → SET_MIN → RUN.
  - Encoding 3 is unreachable; if ever entered, go to RUN next cycle.
- inc_btn in RUN: ignored.
- inc_btn in SET_HOUR: hours +1 with the same wrap as RUN; HR_CAR is never asserted.
- inc_btn in SET_MIN: minutes +1, 59 → 00; no hour increment, no HR_CAR.
- Ticks in SET_HOUR / SET_MIN: discarded, not queued. car_prev still tracks CAR.
- mode_btn and inc_btn in the same cycle: mode_btn wins, inc_btn ignored.
- tick and mode_btn in the same cycle in RUN: the tick is applied, and MODE becomes SET_HOUR.
- Counter legality: outputs never leave legal BCD ranges.
  - Any illegal internal digit combination is not required to be handled.
  - Reset is the only recovery mechanism.
- rst mid-operation: overrides everything, including a pending HR_CAR, buttons and tick.

Test Plan:
- Reset, CAR held high 5 cycles then toggled low/high → no increment during the initial high; exactly one minute counted on the first later rising edge (MIN 00 → 01).
- Preload via SET to 23:59 (H24 = 1), return to RUN, one CAR rising edge → 00:00, HR_CAR high exactly one cycle after the update.
- H24 = 0: set 11:59, one tick → 12:00 with no HR_CAR; set 12:59, one tick → 01:00 with HR_CAR pulse.
- mode_btn ×1, inc_btn ×25 → HR wraps to 01 (H24 = 1) with HR_CAR never asserted; mode_btn, inc_btn ×61 → MIN 01, HR unchanged.
- In SET_MIN apply CAR rising edges → MIN unchanged; mode_btn and inc_btn together → MODE RUN, MIN unchanged.
- Assert rst mid-SET_HOUR with inc_btn high → next cycle MODE 0, time 00:00 (12:00 if H24 = 0), HR_CAR 0.
